// File: rtl/pwm_regs_mc.sv
// Multi-channel PWM register file: global counter controls, per-channel compare/enable/mode, W1C IRQ.
// Define PWM_REGS_SHADOW_EN to double-buffer PERIOD/COMPARE1/COMPARE2, committed on counter wrap.
module pwm_regs_mc #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    read,
    input  logic                    write,
    input  logic [5:0]              addr,
    input  logic [7:0]              data_write,
    output logic [7:0]              data_read,
    input  logic [CNT_W-1:0]        counter_val,
    input  logic                    period_evt,
    input  logic [NUM_CH-1:0]       cmp_evt,
    output logic [CNT_W-1:0]        period,
    output logic                    en,
    output logic                    count_reset,
    output logic                    upnotdown,
    output logic [7:0]              prescale,
    output logic [NUM_CH-1:0]       pwm_en,
    output logic [2*NUM_CH-1:0]     functions,
    output logic [NUM_CH*CNT_W-1:0] compare1,
    output logic [NUM_CH*CNT_W-1:0] compare2,
    output logic                    irq
);

    localparam int IW = NUM_CH + 1;

    localparam logic [5:0] A_PERIOD_LO  = 6'h00;
    localparam logic [5:0] A_PERIOD_HI  = 6'h01;
    localparam logic [5:0] A_COUNTER_EN = 6'h02;
    localparam logic [5:0] A_CNT_RESET  = 6'h07;
    localparam logic [5:0] A_CNT_VAL_LO = 6'h08;
    localparam logic [5:0] A_CNT_VAL_HI = 6'h09;
    localparam logic [5:0] A_PRESCALE   = 6'h0A;
    localparam logic [5:0] A_UPNOTDOWN  = 6'h0B;
    localparam logic [5:0] A_IRQ_STATUS = 6'h0E;
    localparam logic [5:0] A_IRQ_ENABLE = 6'h0F;

    // Byte helpers go through a 16-bit temporary so CNT_W=8 simply drops the hi byte.
    function automatic logic [CNT_W-1:0] put_lo(input logic [CNT_W-1:0] old, input logic [7:0] b);
        logic [15:0] t;
        t      = 16'(old);
        t[7:0] = b;
        return t[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] put_hi(input logic [CNT_W-1:0] old, input logic [7:0] b);
        logic [15:0] t;
        t       = 16'(old);
        t[15:8] = b;
        return t[CNT_W-1:0];
    endfunction

    function automatic logic [7:0] get_lo(input logic [CNT_W-1:0] v);
        logic [15:0] t;
        t = 16'(v);
        return t[7:0];
    endfunction

    function automatic logic [7:0] get_hi(input logic [CNT_W-1:0] v);
        logic [15:0] t;
        t = 16'(v);
        return t[15:8];
    endfunction

    // Bus-visible registers (shadow copies when double-buffering is built in)
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cmp1_q [NUM_CH];
    logic [CNT_W-1:0] cmp2_q [NUM_CH];
    logic [NUM_CH-1:0] pwm_en_q;
    logic [1:0]        func_q [NUM_CH];
    logic              en_q;
    logic              upnotdown_q;
    logic              count_reset_q;
    logic [7:0]        prescale_q;
    logic [IW-1:0]     irq_status_q;
    logic [IW-1:0]     irq_enable_q;

    // Values driven to the counter and channels
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] cmp1_act [NUM_CH];
    logic [CNT_W-1:0] cmp2_act [NUM_CH];

    logic [2:0]    ch_sel;
    logic [2:0]    ch_off;
    logic          ch_hit;
    logic [IW-1:0] irq_set;
    logic [IW-1:0] irq_clr;

    // Channel windows start at 0x10, eight bytes each
    always_comb begin
        ch_sel = addr[5:3] - 3'd2;
        ch_off = addr[2:0];
        ch_hit = (addr[5:4] != 2'b00) && (int'(ch_sel) < NUM_CH);
    end

    always_comb begin
        irq_set = {cmp_evt, period_evt};
        irq_clr = (write && addr == A_IRQ_STATUS) ? data_write[IW-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q      <= '0;
            en_q          <= 1'b0;
            upnotdown_q   <= 1'b1;
            count_reset_q <= 1'b0;
            prescale_q    <= '0;
            irq_status_q  <= '0;
            irq_enable_q  <= '0;
        end else begin
            count_reset_q <= write && (addr == A_CNT_RESET) && data_write[0];
            // Set has priority over a simultaneous W1C clear
            irq_status_q  <= (irq_status_q & ~irq_clr) | irq_set;
            if (write) begin
                case (addr)
                    A_PERIOD_LO:  period_q     <= put_lo(period_q, data_write);
                    A_PERIOD_HI:  period_q     <= put_hi(period_q, data_write);
                    A_COUNTER_EN: en_q         <= data_write[0];
                    A_PRESCALE:   prescale_q   <= data_write;
                    A_UPNOTDOWN:  upnotdown_q  <= data_write[0];
                    A_IRQ_ENABLE: irq_enable_q <= data_write[IW-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_en_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cmp1_q[n] <= '0;
                cmp2_q[n] <= '0;
                func_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (write && ch_hit && ch_sel == 3'(n)) begin
                    case (ch_off)
                        3'd0: cmp1_q[n]   <= put_lo(cmp1_q[n], data_write);
                        3'd1: cmp1_q[n]   <= put_hi(cmp1_q[n], data_write);
                        3'd2: cmp2_q[n]   <= put_lo(cmp2_q[n], data_write);
                        3'd3: cmp2_q[n]   <= put_hi(cmp2_q[n], data_write);
                        3'd4: pwm_en_q[n] <= data_write[0];
                        3'd5: func_q[n]   <= data_write[1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef PWM_REGS_SHADOW_EN
    logic commit;

    // A stopped counter tracks the shadows every cycle; a running one only on wrap
    assign commit = period_evt || !en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cmp1_act[n] <= '0;
                cmp2_act[n] <= '0;
            end
        end else if (commit) begin
            period_act <= period_q;
            for (int n = 0; n < NUM_CH; n++) begin
                cmp1_act[n] <= cmp1_q[n];
                cmp2_act[n] <= cmp2_q[n];
            end
        end
    end
`else
    always_comb begin
        period_act = period_q;
        for (int n = 0; n < NUM_CH; n++) begin
            cmp1_act[n] = cmp1_q[n];
            cmp2_act[n] = cmp2_q[n];
        end
    end
`endif

    always_comb begin
        compare1  = '0;
        compare2  = '0;
        functions = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            compare1[n*CNT_W +: CNT_W] = cmp1_act[n];
            compare2[n*CNT_W +: CNT_W] = cmp2_act[n];
            functions[2*n +: 2]        = func_q[n];
        end
    end

    assign period      = period_act;
    assign en          = en_q;
    assign count_reset = count_reset_q;
    assign upnotdown   = upnotdown_q;
    assign prescale    = prescale_q;
    assign pwm_en      = pwm_en_q;
    assign irq         = |(irq_status_q & irq_enable_q);

    // Reads see the registered (pre-write) value; unmapped bytes read 0
    always_comb begin
        data_read = 8'h00;
        if (read) begin
            if (ch_hit) begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (ch_sel == 3'(n)) begin
                        case (ch_off)
                            3'd0: data_read = get_lo(cmp1_q[n]);
                            3'd1: data_read = get_hi(cmp1_q[n]);
                            3'd2: data_read = get_lo(cmp2_q[n]);
                            3'd3: data_read = get_hi(cmp2_q[n]);
                            3'd4: data_read = {7'd0, pwm_en_q[n]};
                            3'd5: data_read = {6'd0, func_q[n]};
                            default: data_read = 8'h00;
                        endcase
                    end
                end
            end else begin
                case (addr)
                    A_PERIOD_LO:  data_read = get_lo(period_q);
                    A_PERIOD_HI:  data_read = get_hi(period_q);
                    A_COUNTER_EN: data_read = {7'd0, en_q};
                    A_CNT_VAL_LO: data_read = get_lo(counter_val);
                    A_CNT_VAL_HI: data_read = get_hi(counter_val);
                    A_PRESCALE:   data_read = prescale_q;
                    A_UPNOTDOWN:  data_read = {7'd0, upnotdown_q};
                    A_IRQ_STATUS: data_read = 8'(irq_status_q);
                    A_IRQ_ENABLE: data_read = 8'(irq_enable_q);
                    default:      data_read = 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Bench for pwm_regs_mc: a default 2-channel/16-bit instance plus a 1-channel/8-bit instance on the same bus.
// Expectations are queued by the stimulus tasks and checked by an independent negedge monitor.
module tb_pwm_regs_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [5:0]  addr = '0;
    logic [7:0]  data_write = '0;
    logic [15:0] counter_val = '0;
    logic        period_evt = 1'b0;
    logic [1:0]  cmp_evt = '0;

    logic [7:0]  data_read;
    logic [15:0] period;
    logic        en, count_reset, upnotdown, irq;
    logic [7:0]  prescale;
    logic [1:0]  pwm_en;
    logic [3:0]  functions;
    logic [31:0] compare1, compare2;

    logic [7:0]  d8_data_read;
    logic [7:0]  d8_period;
    logic        d8_en, d8_count_reset, d8_upnotdown, d8_irq;
    logic [7:0]  d8_prescale;
    logic [0:0]  d8_pwm_en;
    logic [1:0]  d8_functions;
    logic [7:0]  d8_compare1, d8_compare2;

    pwm_regs_mc #(.NUM_CH(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
        .period_evt(period_evt), .cmp_evt(cmp_evt), .period(period), .en(en),
        .count_reset(count_reset), .upnotdown(upnotdown), .prescale(prescale),
        .pwm_en(pwm_en), .functions(functions), .compare1(compare1),
        .compare2(compare2), .irq(irq)
    );

    pwm_regs_mc #(.NUM_CH(1), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .data_write(data_write), .data_read(d8_data_read), .counter_val(counter_val[7:0]),
        .period_evt(period_evt), .cmp_evt(cmp_evt[0:0]), .period(d8_period), .en(d8_en),
        .count_reset(d8_count_reset), .upnotdown(d8_upnotdown), .prescale(d8_prescale),
        .pwm_en(d8_pwm_en), .functions(d8_functions), .compare1(d8_compare1),
        .compare2(d8_compare2), .irq(d8_irq)
    );

    // ---------------- clock / reset
    always #5 clk = ~clk;

    // ---------------- scoreboard
    localparam int S_RD = 0, S_RD8 = 1, S_IRQ = 2, S_CRST = 3, S_PERIOD = 4, S_CMP1 = 5,
                   S_PWMEN = 6, S_FUNC = 7, S_UPDN = 8, S_EN = 9, S_PERIOD8 = 10, S_CMP2 = 11;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] got;
    logic        probe = 1'b0;
    int          tests_run = 0;
    int          failed = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD:      return 32'(data_read);
            S_RD8:     return 32'(d8_data_read);
            S_IRQ:     return 32'(irq);
            S_CRST:    return 32'(count_reset);
            S_PERIOD:  return 32'(period);
            S_CMP1:    return compare1;
            S_PWMEN:   return 32'(pwm_en);
            S_FUNC:    return 32'(functions);
            S_UPDN:    return 32'(upnotdown);
            S_EN:      return 32'(en);
            S_PERIOD8: return 32'(d8_period);
            S_CMP2:    return compare2;
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (read || probe) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_output: output presented with no queued expectation");
            end else begin
                cur = exp_q.pop_front();
                got = observe(cur.sel);
                if (got !== cur.exp) begin
                    failed++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", cur.name, got, cur.exp);
                end
            end
        end
    end

    // ---------------- driver tasks
    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        addr = a; data_write = d; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] e, input string n, input int sel = S_RD);
        addr = a; read = 1'b1;
        exp_q.push_back('{sel: sel, exp: 32'(e), name: n});
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic chk(input int sel, input logic [31:0] e, input string n);
        probe = 1'b1;
        exp_q.push_back('{sel: sel, exp: e, name: n});
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_period();
        period_evt = 1'b1;
        @(posedge clk); #1;
        period_evt = 1'b0;
    endtask

    logic [5:0] map_a [22] = '{6'h00, 6'h01, 6'h02, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                               6'h0E, 6'h0F, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15,
                               6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        foreach (map_a[i])
            rd(map_a[i], (map_a[i] == 6'h0B) ? 8'h01 : 8'h00, $sformatf("reset_rd_%02h", map_a[i]));
        chk(S_IRQ, 0, "reset_irq");
        chk(S_CRST, 0, "reset_count_reset");
        chk(S_UPDN, 1, "reset_upnotdown");

        // channel compare registers and the absent channel 2 window
        wr(6'h10, 8'h11);
        wr(6'h18, 8'h34);
        wr(6'h19, 8'h12);
        idle(1);
        chk(S_CMP1, 32'h1234_0011, "compare1_ch1_write");
        rd(6'h18, 8'h34, "rd_cmp1_ch1_lo");
        rd(6'h19, 8'h12, "rd_cmp1_ch1_hi");
        wr(6'h20, 8'hAA);
        wr(6'h16, 8'hAA);
        idle(1);
        rd(6'h20, 8'h00, "rd_absent_channel");
        rd(6'h16, 8'h00, "rd_unused_offset");
        chk(S_CMP1, 32'h1234_0011, "compare1_after_invalid_write");
        wr(6'h12, 8'hCD);
        wr(6'h13, 8'hAB);
        idle(1);
        chk(S_CMP2, 32'h0000_ABCD, "compare2_ch0_write");

        // narrow-register write masking
        wr(6'h1C, 8'hFF);
        wr(6'h1D, 8'hFF);
        rd(6'h1C, 8'h01, "rd_pwm_en_ch1");
        rd(6'h1D, 8'h03, "rd_functions_ch1");
        chk(S_PWMEN, 2'b10, "pwm_en_out");
        chk(S_FUNC, 4'b1100, "functions_out");
        wr(6'h0B, 8'hFE);
        rd(6'h0B, 8'h00, "rd_upnotdown_cleared");
        chk(S_UPDN, 0, "upnotdown_out");
        wr(6'h0A, 8'hA5);
        rd(6'h0A, 8'hA5, "rd_prescale");
        wr(6'h02, 8'hFF);
        rd(6'h02, 8'h01, "rd_counter_en");
        chk(S_EN, 1, "en_out");
        wr(6'h02, 8'h00);

        // counter reset pulse
        wr(6'h07, 8'h01);
        chk(S_CRST, 1, "count_reset_pulse");
        chk(S_CRST, 0, "count_reset_single_cycle");
        rd(6'h07, 8'h00, "rd_count_reset");
        wr(6'h07, 8'hFE);
        chk(S_CRST, 0, "count_reset_bit0_clear");

        // interrupt status / enable
        wr(6'h0F, 8'h02);
        cmp_evt = 2'b01;
        @(posedge clk); #1;
        cmp_evt = 2'b00;
        rd(6'h0E, 8'h02, "irq_status_cmp0_set");
        chk(S_IRQ, 1, "irq_cmp0");
        cmp_evt = 2'b01;
        wr(6'h0E, 8'h02);
        cmp_evt = 2'b00;
        rd(6'h0E, 8'h02, "irq_set_beats_clear");
        chk(S_IRQ, 1, "irq_after_set_clear");
        wr(6'h0E, 8'h02);
        rd(6'h0E, 8'h00, "irq_status_cleared");
        chk(S_IRQ, 0, "irq_cleared");
        pulse_period();
        rd(6'h0E, 8'h01, "irq_status_period");
        chk(S_IRQ, 0, "irq_period_masked");
        wr(6'h0E, 8'h00);
        rd(6'h0E, 8'h01, "irq_write0_no_clear");
        wr(6'h0F, 8'hFF);
        rd(6'h0F, 8'h07, "irq_enable_width");
        chk(S_IRQ, 1, "irq_period_enabled");
        wr(6'h0E, 8'h01);
        chk(S_IRQ, 0, "irq_period_cleared");
        wr(6'h0F, 8'h00);

        // CNT_W=8 instance ignores the hi byte
        wr(6'h01, 8'hFF);
        rd(6'h01, 8'h00, "d8_rd_period_hi", S_RD8);
        chk(S_PERIOD8, 8'h00, "d8_period_unchanged");
        rd(6'h01, 8'hFF, "rd_period_hi");
        wr(6'h00, 8'h5A);
        idle(1);
        chk(S_PERIOD8, 8'h5A, "d8_period_lo");
        rd(6'h00, 8'h5A, "d8_rd_period_lo", S_RD8);
        chk(S_PERIOD, 16'hFF5A, "period_ff5a");
        wr(6'h01, 8'h00);
        wr(6'h00, 8'h00);
        idle(1);
        chk(S_PERIOD, 16'h0000, "period_zero");

        // counter value is read-only
        counter_val = 16'hABCD;
        rd(6'h08, 8'hCD, "rd_counter_val_lo");
        rd(6'h09, 8'hAB, "rd_counter_val_hi");
        wr(6'h08, 8'h00);
        rd(6'h08, 8'hCD, "counter_val_write_ignored");

`ifdef PWM_REGS_SHADOW_EN
        wr(6'h02, 8'h01);
        wr(6'h00, 8'h00);
        wr(6'h01, 8'h01);
        idle(1);
        chk(S_PERIOD, 16'h0000, "shadow_period_held");
        rd(6'h01, 8'h01, "shadow_rd_period_hi");
        pulse_period();
        chk(S_PERIOD, 16'h0100, "shadow_commit_on_wrap");
        period_evt = 1'b1;
        wr(6'h00, 8'h55);
        period_evt = 1'b0;
        chk(S_PERIOD, 16'h0100, "shadow_same_cycle_not_committed");
        pulse_period();
        chk(S_PERIOD, 16'h0155, "shadow_next_wrap_commit");
        wr(6'h02, 8'h00);
        wr(6'h00, 8'h77);
        chk(S_PERIOD, 16'h0155, "shadow_en0_before");
        chk(S_PERIOD, 16'h0177, "shadow_en0_next_cycle");
`else
        wr(6'h02, 8'h01);
        wr(6'h00, 8'h00);
        wr(6'h01, 8'h01);
        chk(S_PERIOD, 16'h0100, "period_direct_write");
        wr(6'h00, 8'h55);
        chk(S_PERIOD, 16'h0155, "period_direct_lo");
        rd(6'h00, 8'h55, "rd_period_lo");
`endif

        // asynchronous reset in the middle of a pending flag and a count_reset pulse
        wr(6'h0F, 8'h01);
        pulse_period();
        chk(S_IRQ, 1, "irq_before_reset");
        wr(6'h07, 8'h01);
        rst_n = 1'b0;
        chk(S_CRST, 0, "reset_kills_count_reset");
        chk(S_IRQ, 0, "reset_kills_irq");
        rst_n = 1'b1;
        rd(6'h0E, 8'h00, "reset_irq_status");
        rd(6'h0B, 8'h01, "reset_upnotdown_again");

        idle(2);
        if (exp_q.size() != 0) begin
            tests_run++;
            failed++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/pwm_regs_mc.md
Name: pwm_regs_mc

Overview:
Parametrised multi-channel register file for the PWM timer peripheral. Sits between the bus decoder (byte-wide read/write, 6-bit address) and one shared counter plus NUM_CH PWM channels. Adds over the single-channel block:
- per-channel compare/enable/function registers
- sticky W1C interrupt status with enable mask and irq output
- optional double-buffered (shadow) period/compare registers, committed on counter wrap

Parameters:
NUM_CH, 2, number of PWM channels (legal 1..6)
CNT_W, 16, counter/period/compare width (legal 8..16)

Ports:
clk  in  1  peripheral clock
rst_n  in  1  reset
read  in  1  decoder read strobe
write  in  1  decoder write strobe
addr  in  6  register byte address
data_write  in  8  write data
data_read  out  8  read data (combinational)
counter_val  in  CNT_W  current counter value
period_evt  in  1  one-cycle pulse: counter wrapped (overflow or underflow)
cmp_evt  in  NUM_CH  one-cycle pulses: channel n compare match
period  out  CNT_W  active period
en  out  1  counter enable
count_reset  out  1  one-cycle counter reset pulse
upnotdown  out  1  count direction, 1 = up
prescale  out  8  prescaler value
pwm_en  out  NUM_CH  per-channel enable
functions  out  2*NUM_CH  channel n mode at [2n+1:2n]
compare1  out  NUM_CH*CNT_W  channel n at [n*CNT_W +: CNT_W]
compare2  out  NUM_CH*CNT_W  same packing
irq  out  1  |(irq_status & irq_enable)

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
- Reset values: all registers and outputs 0, except upnotdown = 1. The reset covers shadow copies and both IRQ registers.
- Global address map:
  - 0x00/0x01 PERIOD lo/hi
  - 0x02 COUNTER_EN bit0
  - 0x07 COUNTER_RESET: a write with bit0 = 1 drives count_reset high for exactly one cycle; reads 0
  - 0x08/0x09 COUNTER_VAL, read-only; writes ignored
  - 0x0A PRESCALE
  - 0x0B UPNOTDOWN bit0
  - 0x0E IRQ_STATUS: bit0 = period flag, bit(1+n) = channel n compare flag; W1C
  - 0x0F IRQ_ENABLE, same bit layout, R/W
- Channel n base = 0x10 + 8*n:
  - +0/+1 COMPARE1 lo/hi
  - +2/+3 COMPARE2 lo/hi
  - +4 PWM_EN bit0
  - +5 FUNCTIONS [1:0]
  - +6/+7 unused
- Width rules:
  - Hi-byte writes keep only the bits below CNT_W; unimplemented bits read 0.
  - Single-bit and FUNCTIONS registers ignore the unused write bits and read them as 0.
  - IRQ bits above NUM_CH are not implemented and read 0.
- Invalid address (unused offset, channel >= NUM_CH, unmapped global): writes have no effect; reads return 0x00.
- data_read = 0x00 whenever read = 0.
- Writes take effect at the clk edge where write = 1.
- Flags:
  - A period_evt or cmp_evt[n] pulse sets its status bit at the next edge.
  - Writing 1 clears the bit; writing 0 leaves it unchanged.
  - Set and clear in the same cycle: set wins, and the flag stays 1.
- irq is combinational from the registered status/enable. It stays asserted until every enabled pending flag is cleared.
- Simultaneous read and write to the same address: data_read shows the pre-write value.
- Reset mid-operation clears pending flags and any count_reset pulse immediately.

Optional Feature:
Macro PWM_REGS_SHADOW_EN.
- Defined:
  - PERIOD/COMPARE1/COMPARE2 writes go to shadow registers, and reads return the shadow value.
  - Active outputs load all shadows together on the edge after a period_evt pulse, or on every edge while en = 0.
  - A shadow write in the same cycle as period_evt is not committed by that event. It commits at the next period_evt, or next cycle if en = 0.
- Undefined: no shadows; writes update the active outputs directly at the write edge, and reads return the active value.

Test Plan:
- Reset, then read every mapped address: all 0x00 except UPNOTDOWN = 0x01; irq = 0; count_reset = 0.
- NUM_CH=2: write 0x34 to 0x18 and 0x12 to 0x19 -> compare1[31:16] = 0x1234, compare1[15:0] unchanged. A write to 0x20 (channel 2, absent) -> no effect, and a read of 0x20 returns 0x00.
- Write 0x01 to 0x07 -> count_reset high for exactly one cycle, then low; a read of 0x07 returns 0x00.
- IRQ_ENABLE = 0x02, pulse cmp_evt[0] -> IRQ_STATUS = 0x02 and irq = 1. Write 0x02 to 0x0E in the same cycle as another cmp_evt[0] -> flag stays 1. A following clear with no event -> IRQ_STATUS = 0x00, irq = 0.
- CNT_W=8: write 0xFF to 0x01 -> read of 0x01 returns 0x00, period unchanged.
- With PWM_REGS_SHADOW_EN:
  - en = 1, write PERIOD = 0x0100 -> period output holds the old value until a period_evt pulse, then equals 0x0100 on the following edge.
  - With en = 0, a write appears on the period output one cycle after the write edge.
